// File: rtl/glyph_mem_pkg.sv
// glyph_mem_pkg: shared widths, RAM depth and slot tags for the glyph memory arbiter
package glyph_mem_pkg;
  localparam int AW_DEF = 14;
  localparam int DW_DEF = 1;
  localparam int CW_DEF = 16;
  localparam int GLYPH_DEPTH = 16384;
  typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_HRD} slot_tag_t;
endpackage

// File: rtl/glyph_mem_arbiter_if.sv
// glyph_mem_arbiter_if: display, host, RAM and statistics signals of the glyph memory arbiter
interface glyph_mem_arbiter_if
  import glyph_mem_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
);
  logic          disp_en;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_data;
  logic          disp_valid;
  logic          host_valid;
  logic          host_ready;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_rvalid;
  logic [DW-1:0] host_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          stat_clr;
  logic [CW-1:0] conflict_cnt;
  modport slave (
    input  disp_en, disp_addr, host_valid, host_we, host_addr, host_wdata, mem_rdata, stat_clr,
    output disp_data, disp_valid, host_ready, host_rvalid, host_rdata, mem_addr, mem_we, mem_wdata,
           conflict_cnt
  );
  modport master (
    output disp_en, disp_addr, host_valid, host_we, host_addr, host_wdata, mem_rdata, stat_clr,
    input  disp_data, disp_valid, host_ready, host_rvalid, host_rdata, mem_addr, mem_we, mem_wdata,
           conflict_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear taking priority over increment
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else if (clr) cnt_q <= '0;
    else if (inc && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
  assign q = cnt_q;
endmodule

// File: rtl/glyph_mem_arbiter.sv
// glyph_mem_arbiter: shares the single-port glyph RAM between pixel fetch (absolute priority)
// and a host read/write port, returning read data through a 2-stage slot tag pipeline.
module glyph_mem_arbiter
  import glyph_mem_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) (
  input logic                clk,
  input logic                rst,
  glyph_mem_arbiter_if.slave bus
);
  logic          host_grant;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          mem_we_q, mem_we_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  slot_tag_t     tag1_q, tag1_d, tag2_q;
  logic [DW-1:0] disp_data_q, host_rdata_q;
  logic          disp_valid_q, host_rvalid_q;
  logic [CW-1:0] cnt;
  always_comb begin
    host_grant  = bus.host_valid & ~bus.disp_en;
    mem_addr_d  = bus.disp_en ? bus.disp_addr : host_grant ? bus.host_addr : mem_addr_q;
    mem_we_d    = host_grant & bus.host_we;
    mem_wdata_d = host_grant ? bus.host_wdata : mem_wdata_q;
    tag1_d      = bus.disp_en ? TAG_DISP : (host_grant & ~bus.host_we) ? TAG_HRD : TAG_NONE;
  end
  // Async reset also clears mem_we_q, so a registered write never reaches the RAM edge.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      mem_addr_q    <= '0;
      mem_we_q      <= 1'b0;
      mem_wdata_q   <= '0;
      tag1_q        <= TAG_NONE;
      tag2_q        <= TAG_NONE;
      disp_data_q   <= '0;
      disp_valid_q  <= 1'b0;
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
    end else begin
      mem_addr_q    <= mem_addr_d;
      mem_we_q      <= mem_we_d;
      mem_wdata_q   <= mem_wdata_d;
      tag1_q        <= tag1_d;
      tag2_q        <= tag1_q;
      disp_valid_q  <= tag2_q == TAG_DISP;
      host_rvalid_q <= tag2_q == TAG_HRD;
      if (tag2_q == TAG_DISP) disp_data_q <= bus.mem_rdata;
      if (tag2_q == TAG_HRD) host_rdata_q <= bus.mem_rdata;
    end
  sat_counter #(.W(CW)) u_conflict (
    .clk (clk),
    .rst (rst),
    .inc (bus.host_valid & bus.disp_en),
    .clr (bus.stat_clr),
    .q   (cnt)
  );
  assign bus.host_ready   = rst & ~bus.disp_en;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.disp_data    = disp_data_q;
  assign bus.disp_valid   = disp_valid_q;
  assign bus.host_rdata   = host_rdata_q;
  assign bus.host_rvalid  = host_rvalid_q;
  assign bus.conflict_cnt = cnt;
endmodule
